// File: rtl/digit_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : digit_frame_sched
//  Purpose  : Frame-level sequencer for the digit-recognition datapath.
//             It latches and qualifies the boundary box at start of frame.
//             It holds the recognizer accumulators cleared except during
//             the measurement frame. It samples the recognizer result a
//             few cycles after end of frame. It emits a digit on a
//             valid/ready port once CONFIRM_N consecutive identical
//             results have been seen.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, rst_n            : clock, synchronous active-low reset
//    wren, hcount, lcount    : TFT timing (active pixel enable, column, line)
//    bbox_*                  : boundary detector box and its valid flag
//    result                  : recognizer digit (0..9, others unrecognised)
//    Upper/Lower/Right/Lift_data : box latched for the recognizer
//    tft_begin               : recognizer clear (1 = clear/hold, 0 = count)
//    digit_out/digit_valid/digit_ready : confirmed digit handshake
//    overrun                 : pulse when a confirmation hits a pending digit
//    busy                    : high in MEASURE, SETTLE and VOTE
//    timeout                 : only with DIGIT_FRAME_SCHED_TIMEOUT_EN defined
//  Configuration macro: DIGIT_FRAME_SCHED_TIMEOUT_EN. When it is defined,
//    a sticky timeout flag is raised after TIMEOUT_FRAMES consecutive
//    frames with no valid target.
// ============================================================================
module digit_frame_sched #(
   parameter int H_ACTIVE   = 480,
   parameter int V_ACTIVE   = 272,
   parameter int MIN_W      = 8,
   parameter int MIN_H      = 16,
   parameter int CONFIRM_N  = 3,
   parameter int SETTLE_CYC = 4
`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_FRAMES = 60
`endif
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       wren,
   input  logic [8:0] hcount,
   input  logic [8:0] lcount,
   input  logic [8:0] bbox_upper,
   input  logic [8:0] bbox_lower,
   input  logic [8:0] bbox_right,
   input  logic [8:0] bbox_lift,
   input  logic       bbox_valid,
   input  logic [3:0] result,
   output logic [8:0] Upper_data,
   output logic [8:0] Lower_data,
   output logic [8:0] Right_data,
   output logic [8:0] Lift_data,
   output logic       tft_begin,
   output logic [3:0] digit_out,
   output logic       digit_valid,
   input  logic       digit_ready,
   output logic       overrun,
`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
   output logic       timeout,
`endif
   output logic       busy
);

   localparam logic [8:0] c_h_last      = 9'(H_ACTIVE - 1);
   localparam logic [8:0] c_v_last      = 9'(V_ACTIVE - 1);
   localparam logic [9:0] c_min_w       = 10'(MIN_W);
   localparam logic [9:0] c_min_h       = 10'(MIN_H);
   localparam logic [3:0] c_confirm     = 4'(CONFIRM_N);
   localparam logic [3:0] c_settle_last = 4'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      ST_WAIT_SOF = 3'd0,
      ST_MEASURE  = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_VOTE     = 3'd3,
      ST_SKIP     = 3'd4
   } state_t;

   state_t     r_state;
   logic [3:0] r_settle_cnt;
   logic [3:0] r_streak;
   logic [3:0] r_cand;
   logic [3:0] r_last_emit;

   logic       w_sof;
   logic       w_eof;
   logic       w_box_good;
   logic [3:0] w_vote_cand;
   logic [3:0] w_vote_streak;
   logic       w_confirm;
   logic       w_force_idle;

   assign w_sof = wren && (hcount == 9'd0) && (lcount == 9'd0);
   assign w_eof = wren && (hcount == c_h_last) && (lcount == c_v_last);

   // Box limits are widened to 10 bits so that edge + minimum cannot wrap.
   assign w_box_good = bbox_valid
                    && ({1'b0, bbox_lower} >= ({1'b0, bbox_upper} + c_min_h))
                    && ({1'b0, bbox_right} >= ({1'b0, bbox_lift}  + c_min_w));

   assign busy = (r_state == ST_MEASURE) || (r_state == ST_SETTLE)
              || (r_state == ST_VOTE);

   // Candidate/streak update applied in the VOTE cycle.
   always_comb begin
      w_vote_cand   = r_cand;
      w_vote_streak = r_streak;
      if (result > 4'd9) begin
         w_vote_cand   = 4'hF;
         w_vote_streak = 4'd0;
      end else if (result == r_cand) begin
         if (r_streak != 4'hF) begin
            w_vote_streak = r_streak + 4'd1;
         end
      end else begin
         w_vote_cand   = result;
         w_vote_streak = 4'd1;
      end
      w_confirm = (w_vote_streak == c_confirm) && (w_vote_cand != r_last_emit);
   end

`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
   logic [7:0] r_skip_cnt;
   logic [7:0] w_skip_next;
   logic       w_timeout_set;

   assign w_skip_next   = (r_skip_cnt == 8'hFF) ? 8'hFF : (r_skip_cnt + 8'd1);
   assign w_timeout_set = (r_state == ST_SKIP) && w_eof
                       && (w_skip_next >= 8'(TIMEOUT_FRAMES));
   // The flag and the output blanking start on the same edge.
   assign w_force_idle  = timeout || w_timeout_set;
`else
   assign w_force_idle  = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_state      <= ST_WAIT_SOF;
         r_settle_cnt <= 4'd0;
         r_streak     <= 4'd0;
         r_cand       <= 4'hF;
         r_last_emit  <= 4'hF;
         Upper_data   <= 9'd0;
         Lower_data   <= 9'd0;
         Right_data   <= 9'd0;
         Lift_data    <= 9'd0;
         tft_begin    <= 1'b1;
         digit_out    <= 4'hF;
         digit_valid  <= 1'b0;
         overrun      <= 1'b0;
`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
         r_skip_cnt   <= 8'd0;
         timeout      <= 1'b0;
`endif
      end else begin
         overrun <= 1'b0;
         // An emit later in this block overrides the acceptance clear.
         if (digit_valid && digit_ready) begin
            digit_valid <= 1'b0;
         end

         case (r_state)
            ST_WAIT_SOF: begin
               tft_begin <= 1'b1;
               if (w_sof) begin
                  Upper_data <= bbox_upper;
                  Lower_data <= bbox_lower;
                  Right_data <= bbox_right;
                  Lift_data  <= bbox_lift;
                  if (w_box_good) begin
                     // Counting starts on the pixel after sof.
                     tft_begin <= 1'b0;
                     r_state   <= ST_MEASURE;
`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
                     timeout   <= 1'b0;
`endif
                  end else begin
                     r_state   <= ST_SKIP;
                  end
               end
            end

            ST_MEASURE: begin
               if (w_eof) begin
                  r_settle_cnt <= 4'd0;
                  r_state      <= ST_SETTLE;
`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
                  r_skip_cnt   <= 8'd0;
`endif
               end
            end

            ST_SETTLE: begin
               if (r_settle_cnt == c_settle_last) begin
                  r_state <= ST_VOTE;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 4'd1;
               end
            end

            ST_VOTE: begin
               r_cand    <= w_vote_cand;
               r_streak  <= w_vote_streak;
               tft_begin <= 1'b1;
               r_state   <= ST_WAIT_SOF;
               if (w_confirm) begin
                  if (!digit_valid || digit_ready) begin
                     digit_out   <= w_vote_cand;
                     digit_valid <= 1'b1;
                     r_last_emit <= w_vote_cand;
                  end else begin
                     overrun <= 1'b1;
                  end
               end
            end

            ST_SKIP: begin
               tft_begin <= 1'b1;
               if (w_eof) begin
                  // Target gone: forget history so the same digit may re-emit.
                  r_streak    <= 4'd0;
                  r_cand      <= 4'hF;
                  r_last_emit <= 4'hF;
                  r_state     <= ST_WAIT_SOF;
`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
                  r_skip_cnt  <= w_skip_next;
                  if (w_timeout_set) begin
                     timeout <= 1'b1;
                  end
`endif
               end
            end

            default: begin
               tft_begin <= 1'b1;
               r_state   <= ST_WAIT_SOF;
            end
         endcase

         if (w_force_idle) begin
            digit_out   <= 4'hF;
            digit_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_digit_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digit_frame_sched
//  Purpose  : Self-checking bench for digit_frame_sched. Frames are
//             shortened by driving the sof pixel, a few interior pixels
//             and then the eof pixel directly.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_digit_frame_sched;

   localparam int SETTLE_CYC = 4;
   // Cycles with tft_begin low / busy high in one measured frame:
   // 3 interior pixels + eof pixel + SETTLE + VOTE.
   localparam int MEAS_CYC = 3 + 1 + SETTLE_CYC + 1;

   localparam logic [8:0] U0 = 9'd40;
   localparam logic [8:0] L0 = 9'd200;
   localparam logic [8:0] F0 = 9'd100;
   localparam logic [8:0] R0 = 9'd220;

   logic       clock = 1'b0;
   logic       rst_n;
   logic       wren;
   logic [8:0] hcount, lcount;
   logic [8:0] bbox_upper, bbox_lower, bbox_right, bbox_lift;
   logic       bbox_valid;
   logic [3:0] result;
   logic [8:0] Upper_data, Lower_data, Right_data, Lift_data;
   logic       tft_begin;
   logic [3:0] digit_out;
   logic       digit_valid;
   logic       digit_ready;
   logic       overrun;
   logic       busy;
`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
   logic       timeout;
`endif

   always #5 clock = ~clock;

`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
   digit_frame_sched #(.SETTLE_CYC(SETTLE_CYC), .TIMEOUT_FRAMES(3)) dut (
`else
   digit_frame_sched #(.SETTLE_CYC(SETTLE_CYC)) dut (
`endif
      .clock(clock), .rst_n(rst_n), .wren(wren), .hcount(hcount), .lcount(lcount),
      .bbox_upper(bbox_upper), .bbox_lower(bbox_lower), .bbox_right(bbox_right),
      .bbox_lift(bbox_lift), .bbox_valid(bbox_valid), .result(result),
      .Upper_data(Upper_data), .Lower_data(Lower_data), .Right_data(Right_data),
      .Lift_data(Lift_data), .tft_begin(tft_begin), .digit_out(digit_out),
      .digit_valid(digit_valid), .digit_ready(digit_ready), .overrun(overrun),
`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
      .timeout(timeout),
`endif
      .busy(busy)
   );

   typedef struct {
      logic       bv;
      logic [8:0] u, l, lf, r;
      logic [3:0] res;
      logic       rdy;
      int         emits;
      logic [3:0] dig;
      int         ovr;
      logic       meas;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int emit_cnt = 0, ovr_cnt = 0, tft0_cnt = 0, busy_cnt = 0;
   logic prev_valid = 1'b0;

   // Event counters sampled on the inactive edge.
   always @(negedge clock) begin
      if (digit_valid && !prev_valid) emit_cnt++;
      prev_valid = digit_valid;
      if (overrun)    ovr_cnt++;
      if (!tft_begin) tft0_cnt++;
      if (busy)       busy_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic vec_t mk(input logic bv, input logic [8:0] u, input logic [8:0] l,
                               input logic [8:0] lf, input logic [8:0] r, input logic [3:0] res,
                               input logic rdy, input int em, input logic [3:0] dg,
                               input int ov, input logic ms);
      vec_t v;
      v.bv = bv; v.u = u; v.l = l; v.lf = lf; v.r = r; v.res = res; v.rdy = rdy;
      v.emits = em; v.dig = dg; v.ovr = ov; v.meas = ms;
      return v;
   endfunction

   task automatic run_frame(input vec_t v, input string tag);
      int e0, o0, t0, b0;
      wren = 1'b0; hcount = 9'd0; lcount = 9'd0;
      digit_ready = v.rdy; result = v.res;
      bbox_valid = v.bv; bbox_upper = v.u; bbox_lower = v.l;
      bbox_lift = v.lf; bbox_right = v.r;
      tick(); tick();
      e0 = emit_cnt; o0 = ovr_cnt; t0 = tft0_cnt; b0 = busy_cnt;
      wren = 1'b1;
      tick();
      check({tag, " box latch"}, 32'({Upper_data, Lower_data, Right_data, Lift_data}),
            32'({v.u, v.l, v.r, v.lf}));
      // Detector moves on mid-frame; latched box must not follow.
      bbox_upper = ~v.u; bbox_lower = ~v.l; bbox_lift = ~v.lf; bbox_right = ~v.r;
      hcount = 9'd10; lcount = 9'd100;
      repeat (3) tick();
      hcount = 9'd479; lcount = 9'd271;
      tick();
      wren = 1'b0; hcount = 9'd0; lcount = 9'd0;
      repeat (10) tick();
      check({tag, " box hold"}, 32'({Upper_data, Lower_data, Right_data, Lift_data}),
            32'({v.u, v.l, v.r, v.lf}));
      check({tag, " emits"}, 32'(emit_cnt - e0), 32'(v.emits));
      check({tag, " digit_out"}, 32'(digit_out), 32'(v.dig));
      check({tag, " overrun"}, 32'(ovr_cnt - o0), 32'(v.ovr));
      check({tag, " tft_begin low cycles"}, 32'(tft0_cnt - t0), v.meas ? 32'(MEAS_CYC) : 32'd0);
      check({tag, " busy cycles"}, 32'(busy_cnt - b0), v.meas ? 32'(MEAS_CYC) : 32'd0);
   endtask

   vec_t tbl[$];
   vec_t tail[$];

   initial begin
      rst_n = 1'b0; wren = 1'b0; hcount = 9'd0; lcount = 9'd0;
      bbox_upper = 9'd0; bbox_lower = 9'd0; bbox_right = 9'd0; bbox_lift = 9'd0;
      bbox_valid = 1'b0; result = 4'd0; digit_ready = 1'b1;

      //             bv    U    L       Lift R       res    rdy  em dig    ov meas
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd7,  1'b1, 0, 4'hF, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd7,  1'b1, 0, 4'hF, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd7,  1'b1, 1, 4'd7, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd7,  1'b1, 0, 4'd7, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd7,  1'b1, 0, 4'd7, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd7,  1'b1, 0, 4'd7, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd3,  1'b1, 0, 4'd7, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd3,  1'b1, 0, 4'd7, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd3,  1'b1, 1, 4'd3, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, 9'd44,    F0, R0,       4'd3,  1'b1, 0, 4'd3, 0, 1'b0));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd3,  1'b1, 0, 4'd3, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd3,  1'b1, 0, 4'd3, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd3,  1'b1, 1, 4'd3, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, 9'd56,    F0, 9'd108,   4'd5,  1'b1, 0, 4'd3, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, 9'd56,    F0, 9'd108,   4'd5,  1'b1, 0, 4'd3, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd12, 1'b1, 0, 4'd3, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd5,  1'b1, 0, 4'd3, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd5,  1'b1, 0, 4'd3, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd5,  1'b1, 1, 4'd5, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, 9'd107,   4'd5,  1'b1, 0, 4'd5, 0, 1'b0));
      tbl.push_back(mk(1'b0, U0, L0,       F0, R0,       4'd5,  1'b1, 0, 4'd5, 0, 1'b0));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd5,  1'b0, 0, 4'd5, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd5,  1'b0, 0, 4'd5, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd5,  1'b0, 1, 4'd5, 0, 1'b1));
      tbl.push_back(mk(1'b0, U0, L0,       F0, R0,       4'd5,  1'b0, 0, 4'd5, 0, 1'b0));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd2,  1'b0, 0, 4'd5, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd2,  1'b0, 0, 4'd5, 0, 1'b1));
      tbl.push_back(mk(1'b1, U0, L0,       F0, R0,       4'd2,  1'b0, 0, 4'd5, 1, 1'b1));

      // After a reset the streak is empty, so three 2s confirm again.
      tail.push_back(mk(1'b1, U0, L0,      F0, R0,       4'd2,  1'b1, 0, 4'hF, 0, 1'b1));
      tail.push_back(mk(1'b1, U0, L0,      F0, R0,       4'd2,  1'b1, 0, 4'hF, 0, 1'b1));
      tail.push_back(mk(1'b1, U0, L0,      F0, R0,       4'd2,  1'b1, 1, 4'd2, 0, 1'b1));

      // Reset state.
      tick(); tick();
      check("reset tft_begin", 32'(tft_begin), 32'd1);
      check("reset digit_out", 32'(digit_out), 32'hF);
      check("reset digit_valid", 32'(digit_valid), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset box", 32'({Upper_data, Lower_data, Right_data, Lift_data}), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < tbl.size(); i++) begin
         run_frame(tbl[i], $sformatf("v%0d", i));
      end

      // Pending digit 5 survived the dropped confirmation; now accept it.
      check("pending valid", 32'(digit_valid), 32'd1);
      check("pending digit", 32'(digit_out), 32'd5);
      digit_ready = 1'b1;
      tick();
      check("accept clears valid", 32'(digit_valid), 32'd0);
      check("accept keeps digit", 32'(digit_out), 32'd5);

`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
      for (int k = 0; k < 4; k++) begin
         run_frame(mk(1'b0, U0, L0, F0, R0, 4'd5, 1'b1, 0, (k < 2) ? 4'd5 : 4'hF, 0, 1'b0),
                   $sformatf("to%0d", k));
         check($sformatf("timeout after skip %0d", k + 1), 32'(timeout), (k < 2) ? 32'd0 : 32'd1);
      end
      check("timeout digit_valid", 32'(digit_valid), 32'd0);
`endif

      // Reset in the middle of a measured frame.
      wren = 1'b0; hcount = 9'd0; lcount = 9'd0; digit_ready = 1'b1;
      bbox_valid = 1'b1; bbox_upper = U0; bbox_lower = L0; bbox_lift = F0; bbox_right = R0;
      tick();
      wren = 1'b1;
      tick();
      check("mid sof busy", 32'(busy), 32'd1);
`ifdef DIGIT_FRAME_SCHED_TIMEOUT_EN
      check("good sof clears timeout", 32'(timeout), 32'd0);
`endif
      hcount = 9'd10; lcount = 9'd100;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid reset tft_begin", 32'(tft_begin), 32'd1);
      check("mid reset digit_valid", 32'(digit_valid), 32'd0);
      check("mid reset digit_out", 32'(digit_out), 32'hF);
      check("mid reset box", 32'({Upper_data, Lower_data, Right_data, Lift_data}), 32'd0);
      check("mid reset busy", 32'(busy), 32'd0);
      wren = 1'b0;
      tick();

      for (int i = 0; i < tail.size(); i++) begin
         run_frame(tail[i], $sformatf("post%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/digit_frame_sched.md
Name: digit_frame_sched

Overview:
- Frame-level sequencer for the digit-recognition datapath. Sits between the TFT timing/boundary-detection logic and the transition-counting recognizer.
- Per frame it:
  - latches and qualifies the bounding box;
  - holds the recognizer accumulators cleared except during the active measurement frame;
  - samples the recognizer's 4-bit result after a settle delay;
  - requires CONFIRM_N consecutive identical digits before emitting a digit on a valid/ready output handshake.

Parameters:
- H_ACTIVE, 480, active pixels per line (hcount range 0..H_ACTIVE-1)
- V_ACTIVE, 272, active lines per frame (lcount range 0..V_ACTIVE-1)
- MIN_W, 8, minimum box width (Right-Lift) for a valid target
- MIN_H, 16, minimum box height (Lower-Upper) for a valid target
- CONFIRM_N, 3, consecutive identical results required to confirm (1..15)
- SETTLE_CYC, 4, cycles waited after end of frame before sampling result (1..15)
- TIMEOUT_FRAMES, 60, frames without valid target before timeout (optional feature only)

Ports:
- clock, in, 1, system/pixel clock
- rst_n, in, 1, synchronous active-low reset
- wren, in, 1, active-pixel enable from TFT timing
- hcount, in, 9, current pixel column
- lcount, in, 9, current pixel line
- bbox_upper, in, 9, boundary detector upper edge
- bbox_lower, in, 9, boundary detector lower edge
- bbox_right, in, 9, boundary detector right edge
- bbox_lift, in, 9, boundary detector left edge
- bbox_valid, in, 1, boundary detector has a box for this frame
- result, in, 4, recognizer output (0..9 digit, anything else = unrecognised)
- Upper_data, out, 9, latched box to recognizer
- Lower_data, out, 9, latched box to recognizer
- Right_data, out, 9, latched box to recognizer
- Lift_data, out, 9, latched box to recognizer
- tft_begin, out, 1, recognizer accumulator clear (1 = clear/hold, 0 = count)
- digit_out, out, 4, confirmed digit
- digit_valid, out, 1, digit_out valid
- digit_ready, in, 1, consumer accepts digit
- overrun, out, 1, one-cycle pulse: confirmation dropped because the output is still pending
- busy, out, 1, high in MEASURE, SETTLE and VOTE

Behaviour:
- Reset (rst_n low at posedge, takes effect at the next edge, also mid-frame):
  - state = WAIT_SOF;
  - box outputs = 0; tft_begin = 1;
  - digit_out = 4'hF; digit_valid = 0; overrun = 0;
  - streak = 0; cand = 4'hF; last_emit = 4'hF.
- Frame markers:
  - sof = wren && hcount==0 && lcount==0.
  - eof = wren && hcount==H_ACTIVE-1 && lcount==V_ACTIVE-1.
- WAIT_SOF:
  - tft_begin = 1.
  - On sof: latch all four bbox inputs into the *_data outputs.
  - Box is good when bbox_valid && bbox_lower >= bbox_upper+MIN_H && bbox_right >= bbox_lift+MIN_W. Compare at 10 bits; no wrap.
  - Good box -> MEASURE. Bad box -> SKIP.
- MEASURE:
  - tft_begin = 0 from the cycle after sof (the sof pixel itself is excluded).
  - Box outputs held constant for the whole frame.
  - On eof -> SETTLE; tft_begin stays 0.
- SETTLE: count SETTLE_CYC cycles, then -> VOTE.
- VOTE (one cycle): sample result, then set tft_begin = 1 and go to WAIT_SOF.
  - result > 9: streak = 0, cand = 4'hF.
  - result == cand: streak = min(streak+1, 15).
  - Otherwise: cand = result, streak = 1.
  - Confirm when the updated streak == CONFIRM_N and cand != last_emit.
- SKIP:
  - tft_begin = 1 for the whole frame.
  - On eof: streak = 0, cand = 4'hF, last_emit = 4'hF (target removed, so the same digit may be re-emitted). Then -> WAIT_SOF.
- Emit on confirm:
  - If !digit_valid, or digit_valid && digit_ready in the same cycle: digit_out = cand, digit_valid = 1, last_emit = cand.
  - Otherwise pulse overrun for one cycle; digit_out is unchanged and last_emit is unchanged.
- Handshake:
  - digit_valid is cleared on the cycle after digit_valid && digit_ready, unless a new emit happens in that same cycle.
  - digit_out is stable while digit_valid is high.
- An sof seen outside WAIT_SOF (timing glitch) is ignored. An eof seen outside MEASURE/SKIP is ignored.

Optional Feature:
- Macro: DIGIT_FRAME_SCHED_TIMEOUT_EN.
- When defined:
  - Adds output port timeout (1 bit) and an 8-bit saturating counter of consecutive SKIP frames, incremented at SKIP eof.
  - The counter clears at any MEASURE eof and on reset.
  - When the counter reaches TIMEOUT_FRAMES, timeout goes high and stays high (sticky) until the next good box.
  - While timeout is high, digit_out is forced to 4'hF with digit_valid = 0; any pending digit is discarded.
- When undefined: no timeout port, no counter. Behaviour is identical to the above with timeout tied low.

Test Plan:
- Reset mid-MEASURE (rst_n low one cycle at lcount=100):
  - next edge: tft_begin=1, digit_valid=0, digit_out=4'hF, box outputs=0, busy=0.
- Three good frames (box U=40, L=200, Lift=100, R=220), result=7 each, ready=1:
  - digit_valid rises in the cycle after VOTE of frame 3 with digit_out=7;
  - exactly one emit; a fourth frame with result 7 emits nothing.
- Result sequence 7,7,3,3,3: no emit after frame 2; digit_out=3 emitted after frame 5.
- Box with L=U+4 (height below MIN_H):
  - tft_begin=1 for the whole frame, busy=0, streak cleared;
  - the next three frames of 7 re-emit 7.
- digit_ready held 0; confirm 5, then remove target (SKIP), then confirm 2:
  - overrun pulses once; digit_out remains 5 until ready=1.
- With DIGIT_FRAME_SCHED_TIMEOUT_EN and TIMEOUT_FRAMES=3, four bbox_valid=0 frames:
  - timeout=1 after the 3rd SKIP eof;
  - the next good-box frame clears timeout at its sof.
